modfs: RTL and testbench
========================

# modfs

Iterative modular subtractor for the prime-field ALU: computes dif = (op1 − op2 − bin) mod mod from a one-cycle start pulse and returns a one-cycle valid pulse. It is the inverse-direction companion of the field modular adder and shares its start/valid handshake, so the core sequencer issues field subtractions the same way it issues additions. Reduced operands (< mod) finish in 2 or 3 cycles. Out-of-range operands are corrected iteratively, bounded by ITER_MAX.

## Interface
- WIDTH, 256, operand/modulus width in bits
- ITER_MAX, 4, maximum correction cycles before the error terminate
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- op1  input  WIDTH  minuend, sampled when en=1
- op2  input  WIDTH  subtrahend, sampled when en=1
- mod  input  WIDTH  modulus p, sampled when en=1
- bin  input  1  borrow-in, sampled when en=1 (present only with MODFS_BIN_EN)
- en  input  1  start pulse, one cycle
- dif  output  WIDTH  result, held until next result
- vld  output  1  one-cycle pulse when dif/err updated
- err  output  1  qualifies vld: 1 = mod==0 or ITER_MAX exceeded
- busy  output  1  high from the edge after en until the vld edge

## Operation
- FSM states: IDLE, DIFF, CORR, DONE.
- Working register r: signed, WIDTH+2 bits. It holds any op1−op2−bin±k·p with no overflow.
- IDLE: waits for en.
- en=1 at an edge: captures op1/op2/mod/bin, clears the iteration counter and err, sets busy, and goes to DIFF.
- DIFF edge: r <= op1 − op2 − bin (zero-extended operands). Then go to CORR.
- CORR (combinational check of r):
  - mod==0: dif<=0, err<=1, vld<=1, go to DONE.
  - 0 ≤ r < p: dif<=r[WIDTH-1:0], err<=0, vld<=1, go to DONE.
  - r < 0: r <= r + p, counter++.
  - r ≥ p: r <= r − p, counter++.
  - counter == ITER_MAX and r still out of range: dif<=0, err<=1, vld<=1, go to DONE.
- DONE: vld<=0, busy<=0, go to IDLE. dif and err hold.
- en has absolute priority in every state. It aborts the current operation, restarts with the new operands, and no vld is issued for the aborted one. If en coincides with the edge that would assert vld, vld stays 0.
- Reset values: dif=0, vld=0, err=0, busy=0, state IDLE, r=0, counter=0. Reset mid-operation discards everything; no vld follows.

## Timing
- en sampled at edge E0. r is valid after E1.
- In-range difference: dif/vld at E2 (latency 2).
- k corrections: dif/vld at E(2+k), with k ≤ ITER_MAX.
- Reduced operands (op1, op2 < p, bin ≤ 1) need at most one correction, so worst-case latency is 3.
- Error terminate: vld/err at E(2+ITER_MAX). mod==0 terminates at E2.
- Back-to-back: en may be asserted on the same edge that returns to IDLE (the DONE edge). Minimum initiation interval is 3 cycles.
- vld is never high for more than one cycle. dif changes only on vld edges and on reset.

## Configuration
- MODFS_BIN_EN defined: the bin port exists and is subtracted in DIFF. Chained multi-limb subtraction uses it.
- MODFS_BIN_EN undefined: no bin port; internal borrow is tied to 0. All other behaviour is identical.

## Structure
- Shared ALU package holds:
  - FSM state typedef: modfs_state_t {IDLE, DIFF, CORR, DONE}
  - counter width constant: $clog2(ITER_MAX+1)
  - r width constant: WIDTH+2
- One sub-module, modfs_addsub: a combinational WIDTH+2-bit signed add/subtract (a, b, sub). It is shared by the DIFF and CORR steps, and its output feeds r.
- The range compare (r<0, r≥p) is inline.

## Test plan
(Bench uses WIDTH=8.)
- p=251, op1=200, op2=50, en at E0 -> dif=150, err=0, vld pulse at E2, busy high E1–E2.
- p=251, op1=10, op2=20 -> one correction, dif=241, vld at E3.
- MODFS_BIN_EN, p=251, op1=5, op2=5, bin=1 -> dif=250, vld at E3. Second case: ITER_MAX=32, p=13, op1=255, op2=0, bin=0 -> 19 corrections, dif=8, vld at E21.
- ITER_MAX=4, p=13, op1=255, op2=0 -> vld=1, err=1, dif=0 at E6. Second case: mod=0 -> err at E2.
- en re-asserted at E1 during an operation with new operands p=251, 3−7 -> only one vld, at E4, dif=247. Second case: en on the would-be vld edge -> vld suppressed.
- rst asserted asynchronously mid-CORR -> dif/vld/err/busy immediately 0, no vld afterwards. A following en computes correctly.

Source files
------------

// File: rtl/modfs_pkg.sv
// Shared ALU package for the modular subtractor: FSM state type and width helpers.
package modfs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIFF,
        CORR,
        DONE
    } modfs_state_t;

    localparam int MODFS_WIDTH_DEF    = 256;
    localparam int MODFS_ITER_MAX_DEF = 4;

    // Iteration counter must be able to hold ITER_MAX itself; keep at least one bit.
    function automatic int modfs_cnt_w(input int iter_max);
        return (iter_max < 1) ? 1 : $clog2(iter_max + 1);
    endfunction

    function automatic int modfs_r_w(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/modfs_addsub.sv
// Combinational signed add/subtract shared by the DIFF and CORR steps.
module modfs_addsub #(
    parameter int W = 258
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                sub,
    output logic signed [W-1:0] y
);

    assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/modfs.sv
// Iterative modular subtractor: dif = (op1 - op2 - bin) mod mod, one-cycle start and valid pulses.
// Define MODFS_BIN_EN to add the bin borrow-in port; without it the borrow is tied to 0.
module modfs #(
    parameter int WIDTH    = 256,
    parameter int ITER_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [WIDTH-1:0] mod,
`ifdef MODFS_BIN_EN
    input  logic             bin,
`endif
    input  logic             en,
    output logic [WIDTH-1:0] dif,
    output logic             vld,
    output logic             err,
    output logic             busy
);
    import modfs_pkg::*;

    localparam int RW    = modfs_r_w(WIDTH);
    localparam int CNT_W = modfs_cnt_w(ITER_MAX);

    // Handshake: en is a one-cycle start that always wins, aborting any operation in
    // flight; vld is a one-cycle strobe qualified by err, and dif/err hold between strobes.
    logic bin_i;
`ifdef MODFS_BIN_EN
    assign bin_i = bin;
`else
    assign bin_i = 1'b0;
`endif

    modfs_state_t     state, state_n;
    logic [WIDTH-1:0] op1_q, op2_q, mod_q, op1_n, op2_n, mod_n;
    logic             bin_q, bin_n;
    logic [RW-1:0]    r, r_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] dif_n;
    logic             vld_n, err_n, busy_n;

    logic [RW-1:0]    mod_ext, as_a, as_b, as_y;
    logic             as_sub, r_neg, r_ge_p;

    assign mod_ext = {2'b00, mod_q};
    assign r_neg   = r[RW-1];
    assign r_ge_p  = !r_neg && (r >= mod_ext);

    assign as_a   = (state == DIFF) ? {2'b00, op1_q} : r;
    assign as_b   = (state == DIFF) ? ({2'b00, op2_q} + RW'(bin_q)) : mod_ext;
    assign as_sub = (state == DIFF) ? 1'b1 : !r_neg;

    modfs_addsub #(.W(RW)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .y   (as_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op1_q <= '0;
            op2_q <= '0;
            mod_q <= '0;
            bin_q <= 1'b0;
            r     <= '0;
            cnt   <= '0;
            dif   <= '0;
            vld   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            op1_q <= op1_n;
            op2_q <= op2_n;
            mod_q <= mod_n;
            bin_q <= bin_n;
            r     <= r_n;
            cnt   <= cnt_n;
            dif   <= dif_n;
            vld   <= vld_n;
            err   <= err_n;
            busy  <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        op1_n   = op1_q;
        op2_n   = op2_q;
        mod_n   = mod_q;
        bin_n   = bin_q;
        r_n     = r;
        cnt_n   = cnt;
        dif_n   = dif;
        vld_n   = 1'b0;
        err_n   = err;
        busy_n  = busy;

        case (state)
            DIFF: begin
                r_n     = as_y;
                state_n = CORR;
            end
            CORR: begin
                if (mod_q == '0) begin
                    dif_n   = '0;
                    err_n   = 1'b1;
                    vld_n   = 1'b1;
                    state_n = DONE;
                end else if (!r_neg && !r_ge_p) begin
                    dif_n   = r[WIDTH-1:0];
                    err_n   = 1'b0;
                    vld_n   = 1'b1;
                    state_n = DONE;
                end else if (cnt == CNT_W'(ITER_MAX)) begin
                    dif_n   = '0;
                    err_n   = 1'b1;
                    vld_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    r_n   = as_y;
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: ;
        endcase

        if (en) begin
            op1_n   = op1;
            op2_n   = op2;
            mod_n   = mod;
            bin_n   = bin_i;
            cnt_n   = '0;
            dif_n   = dif;
            err_n   = 1'b0;
            vld_n   = 1'b0;
            busy_n  = 1'b1;
            state_n = DIFF;
        end
    end

endmodule

// File: tb/tb_modfs.sv
// Bench for modfs at WIDTH=8: instance a uses ITER_MAX=4, instance b uses ITER_MAX=32.
module tb_modfs;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] op1_a = '0, op2_a = '0, mod_a = '0, dif_a;
    logic         bin_a = 1'b0, en_a = 1'b0, vld_a, err_a, busy_a;
    logic [W-1:0] op1_b = '0, op2_b = '0, mod_b = '0, dif_b;
    logic         bin_b = 1'b0, en_b = 1'b0, vld_b, err_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    modfs #(.WIDTH(W), .ITER_MAX(4)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .op1  (op1_a),
        .op2  (op2_a),
        .mod  (mod_a),
`ifdef MODFS_BIN_EN
        .bin  (bin_a),
`endif
        .en   (en_a),
        .dif  (dif_a),
        .vld  (vld_a),
        .err  (err_a),
        .busy (busy_a)
    );

    modfs #(.WIDTH(W), .ITER_MAX(32)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .op1  (op1_b),
        .op2  (op2_b),
        .mod  (mod_b),
`ifdef MODFS_BIN_EN
        .bin  (bin_b),
`endif
        .en   (en_b),
        .dif  (dif_b),
        .vld  (vld_b),
        .err  (err_b),
        .busy (busy_b)
    );

    // Reference: count whole multiples of p needed to land in [0,p); more than imax is an error.
    function automatic void model(input int a, input int b, input int bi, input int p, input int imax,
                                  output int exp_dif, output bit exp_err, output int exp_lat);
        int d, k;
        if (p == 0) begin
            exp_dif = 0; exp_err = 1'b1; exp_lat = 2;
            return;
        end
        d = a - b - bi;
        if (d < 0) k = (-d + p - 1) / p;
        else       k = d / p;
        if (k > imax) begin
            exp_dif = 0; exp_err = 1'b1; exp_lat = 2 + imax;
        end else begin
            exp_dif = (d < 0) ? d + k * p : d - k * p;
            exp_err = 1'b0;
            exp_lat = 2 + k;
        end
    endfunction

    task automatic drive(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] p, input logic bi, input logic e);
        if (sel) begin
            op1_b = a; op2_b = b; mod_b = p; bin_b = bi; en_b = e;
        end else begin
            op1_a = a; op2_a = b; mod_a = p; bin_a = bi; en_a = e;
        end
    endtask

    // One operation: en at E0, then sample each cycle at the falling edge until 3 cycles past vld.
    task automatic do_op(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] p, input logic bi,
                         output int lat, output logic [W-1:0] d, output logic e,
                         output int n_vld, output logic [31:0] busy_m);
        logic v, bz;
        lat = -1; d = '0; e = 1'b0; n_vld = 0; busy_m = '0;
        @(negedge clk);
        drive(sel, a, b, p, bi, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (sel) en_b = 1'b0; else en_a = 1'b0;
        busy_m[0] = sel ? busy_b : busy_a;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            @(negedge clk);
            v  = sel ? vld_b : vld_a;
            bz = sel ? busy_b : busy_a;
            if (c < 32) busy_m[c] = bz;
            if (v) begin
                n_vld++;
                if (lat < 0) begin
                    lat = c;
                    d   = sel ? dif_b : dif_a;
                    e   = sel ? err_b : err_a;
                end
            end
            if (lat >= 0 && c >= lat + 3) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({dif_a, vld_a, err_a, busy_a} !== '0) begin n_fail++;
            $display("FAIL reset_a: got dif=%0d vld=%b err=%b busy=%b want all 0", dif_a, vld_a, err_a, busy_a); end
        n_checks++; if ({dif_b, vld_b, err_b, busy_b} !== '0) begin n_fail++;
            $display("FAIL reset_b: got dif=%0d vld=%b err=%b busy=%b want all 0", dif_b, vld_b, err_b, busy_b); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({vld_a, busy_a} !== 2'b00) begin n_fail++;
            $display("FAIL reset_release: got vld=%b busy=%b want 0 0", vld_a, busy_a); end
    endtask

    task automatic test_in_range();
        int lat, nv; logic [W-1:0] d; logic e; logic [31:0] bm;
        do_op(1'b0, 8'd200, 8'd50, 8'd251, 1'b0, lat, d, e, nv, bm);
        n_checks++; if (d !== 8'd150) begin n_fail++; $display("FAIL in_range_dif: got %0d want 150", d); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL in_range_err: got %b want 0", e); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL in_range_lat: got %0d want 2", lat); end
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL in_range_nvld: got %0d want 1", nv); end
        n_checks++; if (bm[3:1] !== 3'b011) begin n_fail++;
            $display("FAIL in_range_busy: got E3..E1=%b want 011", bm[3:1]); end
    endtask

    task automatic test_one_corr();
        int lat, nv; logic [W-1:0] d; logic e; logic [31:0] bm;
        do_op(1'b0, 8'd10, 8'd20, 8'd251, 1'b0, lat, d, e, nv, bm);
        n_checks++; if (d !== 8'd241) begin n_fail++; $display("FAIL one_corr_dif: got %0d want 241", d); end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL one_corr_lat: got %0d want 3", lat); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL one_corr_err: got %b want 0", e); end
`ifdef MODFS_BIN_EN
        do_op(1'b0, 8'd5, 8'd5, 8'd251, 1'b1, lat, d, e, nv, bm);
        n_checks++; if (d !== 8'd250) begin n_fail++; $display("FAIL bin_dif: got %0d want 250", d); end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL bin_lat: got %0d want 3", lat); end
`endif
    endtask

    task automatic test_long_iter();
        int lat, nv; logic [W-1:0] d; logic e; logic [31:0] bm;
        do_op(1'b1, 8'd255, 8'd0, 8'd13, 1'b0, lat, d, e, nv, bm);
        n_checks++; if (d !== 8'd8) begin n_fail++; $display("FAIL long_iter_dif: got %0d want 8", d); end
        n_checks++; if (lat != 21) begin n_fail++; $display("FAIL long_iter_lat: got %0d want 21", lat); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL long_iter_err: got %b want 0", e); end
    endtask

    task automatic test_err();
        int lat, nv; logic [W-1:0] d; logic e; logic [31:0] bm;
        do_op(1'b0, 8'd255, 8'd0, 8'd13, 1'b0, lat, d, e, nv, bm);
        n_checks++; if ({e, d} !== {1'b1, 8'd0}) begin n_fail++;
            $display("FAIL iter_err_out: got err=%b dif=%0d want err=1 dif=0", e, d); end
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL iter_err_lat: got %0d want 6", lat); end
        do_op(1'b0, 8'd10, 8'd20, 8'd251, 1'b0, lat, d, e, nv, bm);
        do_op(1'b0, 8'd7, 8'd3, 8'd0, 1'b0, lat, d, e, nv, bm);
        n_checks++; if ({e, d} !== {1'b1, 8'd0}) begin n_fail++;
            $display("FAIL mod0_out: got err=%b dif=%0d want err=1 dif=0", e, d); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL mod0_lat: got %0d want 2", lat); end
    endtask

    task automatic test_abort();
        int nv, first; logic [W-1:0] d;
        @(negedge clk); drive(1'b0, 8'd200, 8'd50, 8'd251, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk); drive(1'b0, 8'd3, 8'd7, 8'd251, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk); en_a = 1'b0;
        nv = 0; first = -1; d = '0;
        for (int c = 2; c <= 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (vld_a) begin nv++; if (first < 0) begin first = c; d = dif_a; end end
        end
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL abort_nvld: got %0d want 1", nv); end
        n_checks++; if (first != 4) begin n_fail++; $display("FAIL abort_lat: got %0d want 4", first); end
        n_checks++; if (d !== 8'd247) begin n_fail++; $display("FAIL abort_dif: got %0d want 247", d); end

        // Restart lands on the edge that would have raised vld for 200-50.
        @(negedge clk); drive(1'b0, 8'd200, 8'd50, 8'd251, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk); en_a = 1'b0;
        @(posedge clk);
        @(negedge clk); drive(1'b0, 8'd10, 8'd20, 8'd251, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk); en_a = 1'b0;
        nv = 0; first = -1; d = '0;
        if (vld_a) begin nv++; first = 2; d = dif_a; end
        for (int c = 3; c <= 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (vld_a) begin nv++; if (first < 0) begin first = c; d = dif_a; end end
        end
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL suppress_nvld: got %0d want 1", nv); end
        n_checks++; if (first != 5) begin n_fail++; $display("FAIL suppress_lat: got %0d want 5", first); end
        n_checks++; if (d !== 8'd241) begin n_fail++; $display("FAIL suppress_dif: got %0d want 241", d); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d1, d2; int v1, v2; logic bz3;
        v1 = -1; v2 = -1; d1 = '0; d2 = '0; bz3 = 1'b0;
        @(negedge clk); drive(1'b0, 8'd200, 8'd50, 8'd251, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk); en_a = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); @(negedge clk);
            en_a = 1'b0;
            if (c == 3) bz3 = busy_a;
            if (vld_a) begin
                if (v1 < 0) begin v1 = c; d1 = dif_a; end
                else if (v2 < 0) begin v2 = c; d2 = dif_a; end
            end
            if (c == 2) drive(1'b0, 8'd10, 8'd20, 8'd251, 1'b0, 1'b1);
        end
        n_checks++; if (v1 != 2 || d1 !== 8'd150) begin n_fail++;
            $display("FAIL b2b_first: got E%0d dif=%0d want E2 dif=150", v1, d1); end
        n_checks++; if (v2 != 6 || d2 !== 8'd241) begin n_fail++;
            $display("FAIL b2b_second: got E%0d dif=%0d want E6 dif=241", v2, d2); end
        n_checks++; if (bz3 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", bz3); end
    endtask

    task automatic test_async_reset();
        int lat, nv; logic [W-1:0] d; logic e; logic [31:0] bm;
        @(negedge clk); drive(1'b0, 8'd10, 8'd20, 8'd251, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk); en_a = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({dif_a, vld_a, err_a, busy_a} !== '0) begin n_fail++;
            $display("FAIL async_rst: got dif=%0d vld=%b err=%b busy=%b want all 0", dif_a, vld_a, err_a, busy_a); end
        @(negedge clk); rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (vld_a) nv++;
        end
        n_checks++; if (nv != 0) begin n_fail++; $display("FAIL async_rst_novld: got %0d vld want 0", nv); end
        do_op(1'b0, 8'd200, 8'd50, 8'd251, 1'b0, lat, d, e, nv, bm);
        n_checks++; if (d !== 8'd150 || lat != 2) begin n_fail++;
            $display("FAIL async_rst_after: got dif=%0d lat=%0d want 150 lat 2", d, lat); end
    endtask

    task automatic test_random();
        int lat, nv, ed, el, pi, ai, bi_v, bn; bit ee; logic [W-1:0] d, want; logic e; logic [31:0] bm;
        bit sel;
        for (int i = 0; i < 48; i++) begin
            sel = (i >= 40);
            pi = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 255);
            if (pi > 0 && $urandom_range(0, 1) == 1) begin
                ai = $urandom_range(0, pi - 1); bi_v = $urandom_range(0, pi - 1);
            end else begin
                ai = $urandom_range(0, 255); bi_v = $urandom_range(0, 255);
            end
`ifdef MODFS_BIN_EN
            bn = $urandom_range(0, 1);
`else
            bn = 0;
`endif
            model(ai, bi_v, bn, pi, sel ? 32 : 4, ed, ee, el);
            exp_q.push_back(W'(ed));
            do_op(sel, W'(ai), W'(bi_v), W'(pi), bn[0], lat, d, e, nv, bm);
            want = exp_q.pop_front();
            n_checks++; if (d !== want) begin n_fail++;
                $display("FAIL rand_dif[%0d]: %0d-%0d-%0d mod %0d got %0d want %0d", i, ai, bi_v, bn, pi, d, want); end
            n_checks++; if (e !== ee) begin n_fail++;
                $display("FAIL rand_err[%0d]: got %b want %b", i, e, ee); end
            n_checks++; if (lat != el) begin n_fail++;
                $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, el); end
            n_checks++; if (nv != 1) begin n_fail++;
                $display("FAIL rand_nvld[%0d]: got %0d want 1", i, nv); end
        end
    endtask

    initial begin
        test_reset();
        test_in_range();
        test_one_corr();
        test_long_iter();
        test_err();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
